// File: rtl/instr_loader.sv
// Program loader for the MiniCPU 16x8 instruction store: byte-stream fill, length/checksum check, gated fetch.
// Optional LOADER_CHECKSUM_EN adds a trailing checksum byte (CSUM state and running sum).
module instr_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              cpu_run,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     byte_count_q;
  logic [ADDR_W:0]     cnt_inc;
  logic [ADDR_W-1:0]   wptr;
  logic                xfer;
  logic                start_acc;
  logic                len_bad;
  logic                last_byte;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q;

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] b);
    return acc + b;
  endfunction
`endif

  // The write pointer is the low bits of the accepted-byte count; N <= depth keeps it in range.
  assign wptr      = byte_count_q[ADDR_W-1:0];
  assign cnt_inc   = byte_count_q + (ADDR_W+1)'(1);
  assign xfer      = in_valid && in_ready;
  assign start_acc = load_start && (state_q == S_IDLE || state_q == S_RUN || state_q == S_ERR);
  assign len_bad   = (in_data == '0) || ({1'b0, in_data} > (DATA_W+1)'(DEPTH));
  assign last_byte = (cnt_inc == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_start) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer) state_d = len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer && last_byte) state_d = S_CSUM;
`else
        if (xfer && last_byte) state_d = S_RUN;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (in_data == sum_q) ? S_RUN : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    in_ready    = busy;
    cpu_run     = (state_q == S_RUN);
    err         = (state_q == S_ERR);
    byte_count  = byte_count_q;
    fetch_instr = cpu_run ? mem_q[fetch_addr] : '0;
  end

  // A new session wipes the whole store so a short program never exposes stale words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      byte_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (start_acc) begin
      byte_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (state_q == S_LEN && xfer && !len_bad) len_q <= in_data[ADDR_W:0];
      if (state_q == S_DATA && xfer) begin
        mem_q[wptr]  <= in_data;
        byte_count_q <= cnt_inc;
`ifdef LOADER_CHECKSUM_EN
        sum_q        <= csum_add(sum_q, in_data);
`endif
      end
    end
  end

endmodule
